// File: rtl/knn_pkg.sv
// knn_pkg: shared definitions for the partial-KNN local search-space reader.
//   KNN_DATA_WIDTH / KNN_ADDR_WIDTH : default buffer word and address widths
//   knn_rd_state_e                  : reader sequencer states
//   knn_beat_t                      : stream beat {data, last} at the default width
package knn_pkg;

  localparam int unsigned KNN_DATA_WIDTH = 256;
  localparam int unsigned KNN_ADDR_WIDTH = 11;

  typedef enum logic [1:0] {
    StIdle,
    StRead,
    StDrain,
    StDone
  } knn_rd_state_e;

  typedef struct packed {
    logic [KNN_DATA_WIDTH-1:0] data;
    logic                      last;
  } knn_beat_t;

endpackage

// File: rtl/knn_sp_sync_fifo.sv
// knn_sp_sync_fifo: synchronous FIFO with a registered head entry.
//   clk, reset        : clock, synchronous active-high reset
//   push, push_beat   : write strobe and entry (caller guarantees space)
//   pop               : consume the head entry (ignored when empty)
//   head, head_valid  : registered front entry and its valid flag
//   count             : number of stored entries, head included
// Depth must be a power of two.
module knn_sp_sync_fifo
  import knn_pkg::*;
#(
  parameter type          beat_t = knn_beat_t,
  parameter int unsigned  Depth  = 4,
  localparam int unsigned CntW   = $clog2(Depth + 1),
  localparam int unsigned PtrW   = $clog2(Depth)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            push,
  input  beat_t           push_beat,
  input  logic            pop,
  output beat_t           head,
  output logic            head_valid,
  output logic [CntW-1:0] count
);

  beat_t           mem_q [Depth];
  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0] count_q, count_d, remain;
  beat_t           head_q, head_d;
  logic            head_valid_q, head_valid_d;
  logic            pop_ok;

  assign pop_ok = pop & head_valid_q;

  always_comb begin
    wr_ptr_d     = wr_ptr_q + PtrW'(push);
    rd_ptr_d     = rd_ptr_q + PtrW'(pop_ok);
    count_d      = count_q + CntW'(push) - CntW'(pop_ok);
    remain       = count_q - CntW'(pop_ok);
    head_d       = head_q;
    head_valid_d = 1'b0;
    if (count_d == '0) begin
      head_d.last = 1'b0;
    end else begin
      head_valid_d = 1'b1;
      // Nothing left behind the popped head: the new front is the entry being pushed.
      head_d = (remain == '0) ? push_beat : mem_q[rd_ptr_d];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      head_q       <= '0;
      head_valid_q <= 1'b0;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      head_q       <= head_d;
      head_valid_q <= head_valid_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= push_beat;
    end
  end

  assign head       = head_q;
  assign head_valid = head_valid_q;
  assign count      = count_q;

endmodule

// File: rtl/knn_local_sp_stream_reader.sv
// knn_local_sp_stream_reader: read-side sequencer for the local search-space buffer.
// Walks a wrapping address range on the buffer's read port and streams the returned
// words as ready/valid beats. Reads are only issued with guaranteed FIFO space.
//   clk, reset                     : clock, synchronous active-high reset
//   start, start_base, start_len   : command (sampled in idle only)
//   start_passes                   : pass count, 0 means 1 (KNN_SP_READER_REPLAY_EN only)
//   busy, done                     : command in progress / one-cycle completion pulse
//   mem_address0/ce0/we0/d0, q0    : buffer port (read-only use)
//   out_data/valid/ready/last      : output stream, last marks the end of each pass
// Optional feature macro: KNN_SP_READER_REPLAY_EN (multi-pass replay).
module knn_local_sp_stream_reader
  import knn_pkg::*;
#(
  parameter int unsigned DATA_WIDTH   = KNN_DATA_WIDTH,
  parameter int unsigned ADDR_WIDTH   = KNN_ADDR_WIDTH,
  parameter int unsigned ADDR_RANGE   = 2048,
  parameter int unsigned READ_LATENCY = 1,
  parameter int unsigned FIFO_DEPTH   = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] start_base,
  input  logic [ADDR_WIDTH:0]   start_len,
`ifdef KNN_SP_READER_REPLAY_EN
  input  logic [7:0]            start_passes,
`endif
  output logic                  busy,
  output logic                  done,
  output logic [ADDR_WIDTH-1:0] mem_address0,
  output logic                  mem_ce0,
  output logic                  mem_we0,
  output logic [DATA_WIDTH-1:0] mem_d0,
  input  logic [DATA_WIDTH-1:0] mem_q0,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  out_last
);

  localparam int unsigned CntW = $clog2(FIFO_DEPTH + 1);

  typedef struct packed {
    logic [DATA_WIDTH-1:0] data;
    logic                  last;
  } beat_t;

  knn_rd_state_e state_q, state_d;
  logic                    busy_q, busy_d;
  logic                    done_q, done_d;
  logic                    ce0_q, ce0_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic                    tag_last_q, tag_last_d;
  logic [ADDR_WIDTH-1:0]   ptr_q, ptr_d;
  logic [ADDR_WIDTH:0]     beats_q, beats_d;
  logic [7:0]              passes_q, passes_d;
  logic [ADDR_WIDTH-1:0]   base_q, base_d;
  logic [ADDR_WIDTH:0]     len_q, len_d;
  logic [CntW-1:0]         inflight_q, inflight_d;
  logic [READ_LATENCY-1:0] pipe_valid_q, pipe_last_q;

  logic [CntW-1:0]       fifo_count;
  logic                  head_valid;
  beat_t                 head, push_beat;
  logic                  push, pop;
  logic [CntW:0]         used_next;
  logic [7:0]            passes_in;
  logic                  can_issue;
  logic [ADDR_WIDTH-1:0] cur_ptr;
  logic [ADDR_WIDTH:0]   cur_beats;
  logic [7:0]            cur_passes;

  function automatic logic [ADDR_WIDTH-1:0] next_addr(input logic [ADDR_WIDTH-1:0] a);
    return (a == ADDR_WIDTH'(ADDR_RANGE - 1)) ? '0 : a + 1'b1;
  endfunction

`ifdef KNN_SP_READER_REPLAY_EN
  assign passes_in = (start_passes == 8'd0) ? 8'd1 : start_passes;
`else
  assign passes_in = 8'd1;
`endif

  assign push      = pipe_valid_q[READ_LATENCY-1];
  assign push_beat = '{data: mem_q0, last: pipe_last_q[READ_LATENCY-1]};
  assign pop       = head_valid & out_ready;

  // Occupancy (in flight + stored) as it will stand next cycle, i.e. when a read
  // decided now is actually issued. A pop in that same cycle is not credited.
  assign used_next  = {1'b0, inflight_q} + {1'b0, fifo_count} + (CntW + 1)'(ce0_q)
                    - (CntW + 1)'(pop);
  assign inflight_d = inflight_q + CntW'(ce0_q) - CntW'(push);

  always_comb begin
    state_d    = state_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    ce0_d      = 1'b0;
    addr_d     = addr_q;
    tag_last_d = 1'b0;
    ptr_d      = ptr_q;
    beats_d    = beats_q;
    passes_d   = passes_q;
    base_d     = base_q;
    len_d      = len_q;
    can_issue  = 1'b0;
    cur_ptr    = ptr_q;
    cur_beats  = beats_q;
    cur_passes = passes_q;

    unique case (state_q)
      StIdle: begin
        if (start) begin
          base_d = start_base;
          len_d  = start_len;
          busy_d = 1'b1;
          if (start_len == '0) begin
            state_d = StDone;
            done_d  = 1'b1;
          end else begin
            // First read is decided on the accepting edge so ce0 rises next cycle.
            state_d    = StRead;
            can_issue  = 1'b1;
            cur_ptr    = start_base;
            cur_beats  = start_len;
            cur_passes = passes_in;
          end
        end
      end
      StRead: begin
        can_issue = 1'b1;
      end
      StDrain: begin
        if (used_next == '0) begin
          state_d = StDone;
          done_d  = 1'b1;
        end
      end
      StDone: begin
        state_d = StIdle;
        busy_d  = 1'b0;
      end
      default: state_d = StIdle;
    endcase

    if (can_issue) begin
      ptr_d    = cur_ptr;
      beats_d  = cur_beats;
      passes_d = cur_passes;
      if (used_next < (CntW + 1)'(FIFO_DEPTH)) begin
        ce0_d      = 1'b1;
        addr_d     = cur_ptr;
        tag_last_d = (cur_beats == (ADDR_WIDTH + 1)'(1));
        ptr_d      = next_addr(cur_ptr);
        beats_d    = cur_beats - 1'b1;
        if (cur_beats == (ADDR_WIDTH + 1)'(1)) begin
          if (cur_passes <= 8'd1) begin
            state_d = StDrain;
          end else begin
            ptr_d    = base_d;
            beats_d  = len_d;
            passes_d = cur_passes - 8'd1;
          end
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= StIdle;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      ce0_q        <= 1'b0;
      addr_q       <= '0;
      tag_last_q   <= 1'b0;
      ptr_q        <= '0;
      beats_q      <= '0;
      passes_q     <= '0;
      base_q       <= '0;
      len_q        <= '0;
      inflight_q   <= '0;
      pipe_valid_q <= '0;
      pipe_last_q  <= '0;
    end else begin
      state_q         <= state_d;
      busy_q          <= busy_d;
      done_q          <= done_d;
      ce0_q           <= ce0_d;
      addr_q          <= addr_d;
      tag_last_q      <= tag_last_d;
      ptr_q           <= ptr_d;
      beats_q         <= beats_d;
      passes_q        <= passes_d;
      base_q          <= base_d;
      len_q           <= len_d;
      inflight_q      <= inflight_d;
      // Tag pipeline mirrors the buffer read latency so data and last line up.
      pipe_valid_q[0] <= ce0_q;
      pipe_last_q[0]  <= tag_last_q;
      for (int i = 1; i < int'(READ_LATENCY); i++) begin
        pipe_valid_q[i] <= pipe_valid_q[i-1];
        pipe_last_q[i]  <= pipe_last_q[i-1];
      end
    end
  end

  knn_sp_sync_fifo #(
    .beat_t (beat_t),
    .Depth  (FIFO_DEPTH)
  ) u_fifo (
    .clk        (clk),
    .reset      (reset),
    .push       (push),
    .push_beat  (push_beat),
    .pop        (pop),
    .head       (head),
    .head_valid (head_valid),
    .count      (fifo_count)
  );

  assign busy         = busy_q;
  assign done         = done_q;
  assign mem_address0 = addr_q;
  assign mem_ce0      = ce0_q;
  assign mem_we0      = 1'b0;
  assign mem_d0       = '0;
  assign out_data     = head.data;
  assign out_last     = head.last;
  assign out_valid    = head_valid;

endmodule

// File: tb/tb_knn_local_sp_stream_reader.sv
// Scoreboard bench for knn_local_sp_stream_reader: commands push expected addresses and
// beats into queues; a negedge monitor pops and compares whatever the DUT presents.
module tb_knn_local_sp_stream_reader;

  localparam int DW = 256;
  localparam int AW = 11;
  localparam int AR = 2048;
  localparam int FD = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic [AW-1:0] start_base;
  logic [AW:0]   start_len;
  logic [7:0]    start_passes;
  logic          busy, done;
  logic [AW-1:0] mem_address0;
  logic          mem_ce0, mem_we0;
  logic [DW-1:0] mem_d0, mem_q0;
  logic [DW-1:0] out_data;
  logic          out_valid, out_ready, out_last;

  always #5 clk = ~clk;

  knn_local_sp_stream_reader #(
    .DATA_WIDTH   (DW),
    .ADDR_WIDTH   (AW),
    .ADDR_RANGE   (AR),
    .READ_LATENCY (1),
    .FIFO_DEPTH   (FD)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .start_base   (start_base),
    .start_len    (start_len),
`ifdef KNN_SP_READER_REPLAY_EN
    .start_passes (start_passes),
`endif
    .busy         (busy),
    .done         (done),
    .mem_address0 (mem_address0),
    .mem_ce0      (mem_ce0),
    .mem_we0      (mem_we0),
    .mem_d0       (mem_d0),
    .mem_q0       (mem_q0),
    .out_data     (out_data),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_last     (out_last)
  );

  typedef struct {
    logic [DW-1:0] data;
    logic          last;
  } exp_beat_t;

  exp_beat_t     exp_beats[$];
  logic [AW-1:0] exp_addr[$];
  int            n_checks = 0;
  int            n_pass = 0;
  int            hs_count = 0;
  int            outstanding = 0;
  int            rdy_mode = 0;

  function automatic logic [DW-1:0] word(input int unsigned a);
    logic [DW-1:0] w;
    for (int j = 0; j < DW / 32; j++) begin
      w[j*32 +: 32] = a * 32'h9E3779B1 + j * 32'h01010101 + 32'h5A5A;
    end
    return w;
  endfunction

  task automatic check(input string name, input logic [DW:0] act, input logic [DW:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // Single-port buffer model, one cycle read latency.
  always @(posedge clk) begin
    if (mem_ce0) mem_q0 <= word(mem_address0);
  end

  // Downstream ready: 0 = always, 1 = random, 2 = one cycle on / two off.
  initial begin
    int phase = 0;
    out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (rdy_mode)
        1:       out_ready = 1'($urandom % 2);
        2:       out_ready = (phase == 0);
        default: out_ready = 1'b1;
      endcase
      phase = (phase + 1) % 3;
    end
  end

  // Monitor / scoreboard.
  initial begin
    logic          prev_stall = 1'b0;
    logic [DW-1:0] prev_data = '0;
    logic          prev_last = 1'b0;
    exp_beat_t     e;
    logic [AW-1:0] a;
    forever begin
      @(negedge clk);
      if (reset) begin
        outstanding = 0;
        prev_stall  = 1'b0;
      end else begin
        if (mem_ce0) begin
          if (exp_addr.size() == 0) begin
            check("unexpected_ce0", (DW+1)'(mem_ce0), '0);
          end else begin
            a = exp_addr.pop_front();
            check("read_addr", (DW+1)'(mem_address0), (DW+1)'(a));
          end
          outstanding++;
          check("credit_limit", (DW+1)'(outstanding <= FD), (DW+1)'(1));
        end
        if (prev_stall) begin
          check("stall_hold", {out_valid, out_last, out_data[DW-2:0]},
                {1'b1, prev_last, prev_data[DW-2:0]});
        end
        if (out_valid && out_ready) begin
          if (exp_beats.size() == 0) begin
            check("unexpected_beat", (DW+1)'(out_valid), '0);
          end else begin
            e = exp_beats.pop_front();
            check("beat_data", {1'b0, out_data}, {1'b0, e.data});
            check("beat_last", (DW+1)'(out_last), (DW+1)'(e.last));
          end
          outstanding--;
          hs_count++;
        end
        prev_stall = out_valid && !out_ready;
        prev_data  = out_data;
        prev_last  = out_last;
      end
    end
  end

  task automatic start_cmd(input int base, input int len, input int passes);
    int np;
    np = 1;
`ifdef KNN_SP_READER_REPLAY_EN
    np = (passes == 0) ? 1 : passes;
`endif
    @(negedge clk);
    for (int i = 0; i < 200 && busy; i++) @(negedge clk);
    for (int p = 0; p < np; p++) begin
      for (int i = 0; i < len; i++) begin
        exp_addr.push_back(AW'((base + i) % AR));
        exp_beats.push_back('{word((base + i) % AR), (i == len - 1)});
      end
    end
    start        = 1'b1;
    start_base   = AW'(base);
    start_len    = (AW+1)'(len);
    start_passes = 8'(passes);
    @(negedge clk);
    start = 1'b0;
  endtask

  // Waits for done; throws ignored junk start strobes while busy.
  task automatic wait_done(input string name);
    logic seen = 1'b0;
    for (int i = 0; i < 3000 && !seen; i++) begin
      if (done) begin
        seen  = 1'b1;
        start = 1'b0;
      end else begin
        start = busy && ($urandom % 6 == 0);
        start_base = AW'($urandom);
        start_len  = (AW+1)'($urandom_range(0, 30));
        @(negedge clk);
      end
    end
    start = 1'b0;
    check({name, "_done"}, (DW+1)'(seen), (DW+1)'(1));
    check({name, "_drained"}, (DW+1)'(exp_beats.size() + exp_addr.size()), '0);
  endtask

  initial begin
    logic [4:0] exp_v;
    int h0;
    reset = 1'b1;
    start = 1'b0;
    start_base = '0;
    start_len = '0;
    start_passes = '0;
    repeat (3) @(negedge clk);
    check("rst_ctrl", (DW+1)'({busy, done, mem_ce0, out_valid, out_last}), '0);
    check("rst_addr", (DW+1)'(mem_address0), '0);
    check("rst_data", {1'b0, out_data}, '0);
    check("mem_we_d", {mem_we0, mem_d0}, '0);
    reset = 1'b0;

    // Cycle-exact latency: base 0, len 4, ready high.
    rdy_mode = 0;
    start_cmd(0, 4, 1);
    for (int k = 1; k <= 8; k++) begin
      exp_v = {k <= 7, k == 7, k >= 1 && k <= 4, k >= 3 && k <= 6, k == 6};
      check($sformatf("timing_T+%0d", k), (DW+1)'({busy, done, mem_ce0, out_valid, out_last}),
            (DW+1)'(exp_v));
      @(negedge clk);
    end
    check("t1_drained", (DW+1)'(exp_beats.size()), '0);

    // Address wrap.
    start_cmd(2046, 4, 1);
    wait_done("wrap");

    // Backpressure 1 on / 2 off.
    rdy_mode = 2;
    h0 = hs_count;
    start_cmd(10, 8, 1);
    wait_done("bp");
    check("bp_beats", (DW+1)'(hs_count - h0), (DW+1)'(8));

    // Zero length.
    rdy_mode = 0;
    start_cmd(5, 0, 1);
    check("len0_T+1", (DW+1)'({busy, done, mem_ce0}), (DW+1)'(3'b110));
    @(negedge clk);
    check("len0_T+2", (DW+1)'({busy, done, mem_ce0}), '0);

    // Reset mid-command.
    rdy_mode = 1;
    h0 = hs_count;
    start_cmd(100, 16, 1);
    for (int i = 0; i < 300 && hs_count < h0 + 3; i++) begin
      @(negedge clk);
      #1;
    end
    check("rst_mid_progress", (DW+1)'(hs_count >= h0 + 3), (DW+1)'(1));
    reset = 1'b1;
    @(negedge clk);
    check("rst_mid_ctrl", (DW+1)'({busy, done, mem_ce0, out_valid, out_last}), '0);
    check("rst_mid_addr", (DW+1)'(mem_address0), '0);
    check("rst_mid_data", {1'b0, out_data}, '0);
    exp_beats.delete();
    exp_addr.delete();
    @(negedge clk);
    reset = 1'b0;
    h0 = hs_count;
    start_cmd(7, 2, 1);
    wait_done("post_rst");
    check("post_rst_beats", (DW+1)'(hs_count - h0), (DW+1)'(2));

`ifdef KNN_SP_READER_REPLAY_EN
    begin
      int ndone = 0;
      rdy_mode = 0;
      h0 = hs_count;
      start_cmd(0, 3, 2);
      for (int i = 0; i < 20; i++) begin
        if (done) ndone++;
        @(negedge clk);
      end
      check("replay_done_pulses", (DW+1)'(ndone), (DW+1)'(1));
      check("replay_beats", (DW+1)'(hs_count - h0), (DW+1)'(6));
    end
`endif

    // Randomised commands.
    for (int n = 0; n < 12; n++) begin
      int b;
      rdy_mode = $urandom_range(0, 2);
      b = ($urandom % 2 == 1) ? $urandom_range(2030, AR - 1) : $urandom_range(0, AR - 1);
      start_cmd(b, $urandom_range(1, 24), $urandom_range(0, 3));
      wait_done($sformatf("rand%0d", n));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
